// File: rtl/pipeline_tracker.sv
// pipeline_tracker: PC and per-stage bookkeeping registers for a 5-stage pipeline.
// Tracks PC/instruction into ID and the hazard-relevant decode fields (rd, rs2,
// regwrite/load/store, valid) through EXE, MEM and WB. Counts retired
// instructions and DE bubbles.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   PC_EN_IF, reg_*_EN/flush       stage controls from the hazard unit
//   pc_next, inst_IF               next fetch address, fetched instruction
//   rd_ID, rs2_ID, we/load/store_ID decoded fields of the ID instruction
//   PC_IF, PC_ID, inst_ID, valid_ID IF/ID state
//   *_EXE, *_MEM, *_WB             tracked fields per downstream stage
//   retired_cnt, bubble_cnt        saturating event counters
module pipeline_tracker (
   input  logic        clk,
   input  logic        rst,
   input  logic        PC_EN_IF,
   input  logic        reg_FD_EN,
   input  logic        reg_FD_flush,
   input  logic        reg_DE_EN,
   input  logic        reg_DE_flush,
   input  logic        reg_EM_EN,
   input  logic        reg_EM_flush,
   input  logic        reg_MW_EN,
   input  logic [31:0] pc_next,
   input  logic [31:0] inst_IF,
   input  logic [4:0]  rd_ID,
   input  logic [4:0]  rs2_ID,
   input  logic        we_ID,
   input  logic        load_ID,
   input  logic        store_ID,
   output logic [31:0] PC_IF,
   output logic [31:0] PC_ID,
   output logic [31:0] inst_ID,
   output logic        valid_ID,
   output logic [4:0]  rd_EXE,
   output logic [4:0]  rs2_EXE,
   output logic        we_EXE,
   output logic        load_EXE,
   output logic        store_EXE,
   output logic        valid_EXE,
   output logic [4:0]  rd_MEM,
   output logic        we_MEM,
   output logic        load_MEM,
   output logic        valid_MEM,
   output logic [4:0]  rd_WB,
   output logic        we_WB,
   output logic        valid_WB,
   output logic [31:0] retired_cnt,
   output logic [15:0] bubble_cnt
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned RW   = 5;
   localparam int unsigned BCW  = 16;
   localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

   // Fetch PC
   always_ff @(posedge clk) begin
      if (rst)           PC_IF <= '0;
      else if (PC_EN_IF) PC_IF <= pc_next;
   end

   // IF/ID register
   always_ff @(posedge clk) begin
      if (rst || reg_FD_flush) begin
         PC_ID    <= '0;
         inst_ID  <= NOP_INST;
         valid_ID <= 1'b0;
      end else if (reg_FD_EN) begin
         PC_ID    <= PC_IF;
         inst_ID  <= inst_IF;
         valid_ID <= 1'b1;
      end
   end

   // ID/EXE register; an invalid ID slot enters as a clean bubble so its
   // decoded fields can never match a forwarding compare downstream.
   always_ff @(posedge clk) begin
      if (rst || reg_DE_flush) begin
         rd_EXE    <= '0;
         rs2_EXE   <= '0;
         we_EXE    <= 1'b0;
         load_EXE  <= 1'b0;
         store_EXE <= 1'b0;
         valid_EXE <= 1'b0;
      end else if (reg_DE_EN) begin
         rd_EXE    <= valid_ID ? rd_ID  : RW'(0);
         rs2_EXE   <= valid_ID ? rs2_ID : RW'(0);
         we_EXE    <= valid_ID & we_ID;
         load_EXE  <= valid_ID & load_ID;
         store_EXE <= valid_ID & store_ID;
         valid_EXE <= valid_ID;
      end
   end

   // EXE/MEM register
   always_ff @(posedge clk) begin
      if (rst || reg_EM_flush) begin
         rd_MEM    <= '0;
         we_MEM    <= 1'b0;
         load_MEM  <= 1'b0;
         valid_MEM <= 1'b0;
      end else if (reg_EM_EN) begin
         rd_MEM    <= rd_EXE;
         we_MEM    <= we_EXE;
         load_MEM  <= load_EXE;
         valid_MEM <= valid_EXE;
      end
   end

   // MEM/WB register (no flush input)
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_WB    <= '0;
         we_WB    <= 1'b0;
         valid_WB <= 1'b0;
      end else if (reg_MW_EN) begin
         rd_WB    <= rd_MEM;
         we_WB    <= we_MEM;
         valid_WB <= valid_MEM;
      end
   end

   // Retired-instruction counter, saturating
   always_ff @(posedge clk) begin
      if (rst)
         retired_cnt <= '0;
      else if (reg_MW_EN && valid_MEM && (retired_cnt != {XLEN{1'b1}}))
         retired_cnt <= retired_cnt + XLEN'(1);
   end

   // DE bubble counter, saturating
   always_ff @(posedge clk) begin
      if (rst)
         bubble_cnt <= '0;
      else if (reg_DE_flush && (bubble_cnt != {BCW{1'b1}}))
         bubble_cnt <= bubble_cnt + BCW'(1);
   end

endmodule

// File: tb/tb_pipeline_tracker.sv
// Directed bench for pipeline_tracker with hand-computed expected values.
module tb_pipeline_tracker;

   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] ADDI = 32'h0050_0293; // addi x5, x0, 5

   logic        clk = 1'b0;
   logic        rst;
   logic        PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_EN, reg_DE_flush;
   logic        reg_EM_EN, reg_EM_flush, reg_MW_EN;
   logic [31:0] pc_next, inst_IF;
   logic [4:0]  rd_ID, rs2_ID;
   logic        we_ID, load_ID, store_ID;
   logic [31:0] PC_IF, PC_ID, inst_ID;
   logic        valid_ID;
   logic [4:0]  rd_EXE, rs2_EXE;
   logic        we_EXE, load_EXE, store_EXE, valid_EXE;
   logic [4:0]  rd_MEM;
   logic        we_MEM, load_MEM, valid_MEM;
   logic [4:0]  rd_WB;
   logic        we_WB, valid_WB;
   logic [31:0] retired_cnt;
   logic [15:0] bubble_cnt;

   int n_checks = 0;
   int n_errors = 0;

   pipeline_tracker dut (
      .clk(clk), .rst(rst),
      .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN), .reg_FD_flush(reg_FD_flush),
      .reg_DE_EN(reg_DE_EN), .reg_DE_flush(reg_DE_flush),
      .reg_EM_EN(reg_EM_EN), .reg_EM_flush(reg_EM_flush), .reg_MW_EN(reg_MW_EN),
      .pc_next(pc_next), .inst_IF(inst_IF),
      .rd_ID(rd_ID), .rs2_ID(rs2_ID), .we_ID(we_ID), .load_ID(load_ID), .store_ID(store_ID),
      .PC_IF(PC_IF), .PC_ID(PC_ID), .inst_ID(inst_ID), .valid_ID(valid_ID),
      .rd_EXE(rd_EXE), .rs2_EXE(rs2_EXE), .we_EXE(we_EXE), .load_EXE(load_EXE),
      .store_EXE(store_EXE), .valid_EXE(valid_EXE),
      .rd_MEM(rd_MEM), .we_MEM(we_MEM), .load_MEM(load_MEM), .valid_MEM(valid_MEM),
      .rd_WB(rd_WB), .we_WB(we_WB), .valid_WB(valid_WB),
      .retired_cnt(retired_cnt), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ctrl(input logic pc_en, input logic fd_en, input logic fd_fl,
                       input logic de_en, input logic de_fl, input logic em_en,
                       input logic em_fl, input logic mw_en);
      PC_EN_IF = pc_en; reg_FD_EN = fd_en; reg_FD_flush = fd_fl;
      reg_DE_EN = de_en; reg_DE_flush = de_fl; reg_EM_EN = em_en;
      reg_EM_flush = em_fl; reg_MW_EN = mw_en;
   endtask

   initial begin
      rst = 1'b1;
      ctrl(1, 1, 0, 1, 1, 1, 0, 1);
      pc_next = 32'h100; inst_IF = ADDI;
      rd_ID = 5'd5; rs2_ID = 5'd7; we_ID = 1'b1; load_ID = 1'b0; store_ID = 1'b1;

      // E0: reset overrides all controls
      tick();
      check("rst_pc_if",   PC_IF, 32'h0);
      check("rst_pc_id",   PC_ID, 32'h0);
      check("rst_inst_id", inst_ID, NOP);
      check("rst_valids",  32'({valid_ID, valid_EXE, valid_MEM, valid_WB}), 32'h0);
      check("rst_rd",      32'({rd_EXE, rs2_EXE, rd_MEM, rd_WB}), 32'h0);
      check("rst_retired", retired_cnt, 32'h0);
      check("rst_bubble",  32'(bubble_cnt), 32'h0);

      // E1..E4: straight-line flow, all enables
      rst = 1'b0;
      ctrl(1, 1, 0, 1, 0, 1, 0, 1);
      pc_next = 32'd4;
      tick();
      check("e1_pc_if",   PC_IF, 32'd4);
      check("e1_valid_id", 32'(valid_ID), 32'd1);
      check("e1_inst_id",  inst_ID, ADDI);
      check("e1_pc_id",    PC_ID, 32'd0);
      check("e1_bubble_rd", 32'({valid_EXE, rd_EXE, we_EXE}), 32'h0);
      pc_next = 32'd8;
      tick();
      check("e2_exe", 32'({valid_EXE, rd_EXE, rs2_EXE, we_EXE, store_EXE}),
            32'({1'b1, 5'd5, 5'd7, 1'b1, 1'b1}));
      check("e2_pc_id", PC_ID, 32'd4);
      pc_next = 32'd12;
      tick();
      check("e3_mem", 32'({valid_MEM, rd_MEM, we_MEM}), 32'({1'b1, 5'd5, 1'b1}));
      check("e3_valid_wb", 32'(valid_WB), 32'd0);
      pc_next = 32'd16;
      tick();
      check("e4_wb", 32'({valid_WB, rd_WB, we_WB}), 32'({1'b1, 5'd5, 1'b1}));
      check("e4_retired", retired_cnt, 32'd1);

      // E5: load-use stall with DE bubble
      ctrl(0, 0, 0, 1, 1, 1, 0, 1);
      pc_next = 32'd20;
      tick();
      check("lu_pc_if",   PC_IF, 32'd16);
      check("lu_pc_id",   PC_ID, 32'd12);
      check("lu_inst_id", inst_ID, ADDI);
      check("lu_exe",     32'({valid_EXE, rd_EXE, we_EXE}), 32'h0);
      check("lu_bubble",  32'(bubble_cnt), 32'd1);
      check("lu_retired", retired_cnt, 32'd2);

      // E6, E7: resume; bubble passes MEM without retiring
      ctrl(1, 1, 0, 1, 0, 1, 0, 1);
      tick();
      check("e6_pc_if",   PC_IF, 32'd20);
      check("e6_pc_id",   PC_ID, 32'd16);
      check("e6_valid_mem", 32'(valid_MEM), 32'd0);
      check("e6_retired", retired_cnt, 32'd3);
      pc_next = 32'd24;
      tick();
      check("e7_valid_wb", 32'({valid_WB, rd_WB, we_WB}), 32'h0);
      check("e7_retired", retired_cnt, 32'd3);
      check("e7_bubble",  32'(bubble_cnt), 32'd1);

      // E8: FD flush wins over FD enable
      ctrl(1, 1, 1, 1, 0, 1, 0, 1);
      pc_next = 32'd28;
      tick();
      check("fdf_inst_id",  inst_ID, NOP);
      check("fdf_valid_id", 32'(valid_ID), 32'd0);
      check("fdf_pc_id",    PC_ID, 32'd0);
      check("fdf_pc_if",    PC_IF, 32'd28);
      check("fdf_retired",  retired_cnt, 32'd4);

      // E9: invalid ID slot enters EXE with rd/we cleared
      ctrl(1, 1, 0, 1, 0, 1, 0, 1);
      pc_next = 32'd32;
      tick();
      check("e9_exe_gated", 32'({valid_EXE, rd_EXE, we_EXE, store_EXE}), 32'h0);
      check("e9_id", 32'({valid_ID, PC_ID}), 32'({1'b1, 32'd28}));
      pc_next = 32'd36;
      tick();
      check("e10_mem", 32'({valid_MEM, rd_MEM}), 32'h0);
      check("e10_retired", retired_cnt, 32'd6);

      // E11, E12: EM held while DE keeps loading
      ctrl(1, 1, 0, 1, 0, 0, 0, 1);
      pc_next = 32'd40;
      tick();
      check("emh1_mem", 32'({valid_MEM, rd_MEM}), 32'h0);
      check("emh1_exe", 32'({valid_EXE, rd_EXE}), 32'({1'b1, 5'd5}));
      check("emh1_retired", retired_cnt, 32'd6);
      pc_next = 32'd44;
      tick();
      check("emh2_mem", 32'({valid_MEM, rd_MEM}), 32'h0);
      check("emh2_wb",  32'(valid_WB), 32'd0);
      check("emh2_retired", retired_cnt, 32'd6);

      // E13, E14: release EM
      ctrl(1, 1, 0, 1, 0, 1, 0, 1);
      pc_next = 32'd48;
      tick();
      check("e13_mem", 32'({valid_MEM, rd_MEM}), 32'({1'b1, 5'd5}));
      check("e13_retired", retired_cnt, 32'd6);
      pc_next = 32'd52;
      tick();
      check("e14_retired", retired_cnt, 32'd7);

      // E15: mid-stream reset with a DE flush also requested
      rst = 1'b1;
      ctrl(1, 1, 0, 1, 1, 1, 0, 1);
      tick();
      check("mrst_valids", 32'({valid_ID, valid_EXE, valid_MEM, valid_WB}), 32'h0);
      check("mrst_pc_if",  PC_IF, 32'h0);
      check("mrst_inst",   inst_ID, NOP);
      check("mrst_retired", retired_cnt, 32'h0);
      check("mrst_bubble", 32'(bubble_cnt), 32'h0);

      // bubble_cnt saturation
      rst = 1'b0;
      ctrl(1, 1, 0, 1, 1, 1, 0, 1);
      for (int i = 0; i < 65535; i++) tick();
      check("sat_reach", 32'(bubble_cnt), 32'h0000_FFFF);
      check("sat_no_retire", retired_cnt, 32'h0);
      tick();
      check("sat_hold", 32'(bubble_cnt), 32'h0000_FFFF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pipeline_tracker.md
PIPELINE_TRACKER -- requirements
Module: pipeline_tracker

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock; rst  in  1  synchronous active-high reset (all state on rising clk).
REQ-002 SHALL have ports: PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_EN, reg_DE_flush, reg_EM_EN, reg_EM_flush, reg_MW_EN  in  1 each  stage controls from hazard detection.
REQ-003 SHALL have ports: pc_next  in  32  next fetch address; inst_IF  in  32  fetched instruction.
REQ-004 SHALL have ports: rd_ID, rs2_ID  in  5  decoded fields; we_ID, load_ID, store_ID  in  1  regwrite/load/store flags of ID instruction.
REQ-005 SHALL have ports: PC_IF  out  32; PC_ID  out  32; inst_ID  out  32; valid_ID  out  1.
REQ-006 SHALL have ports: rd_EXE, rs2_EXE  out  5; we_EXE, load_EXE, store_EXE, valid_EXE  out  1.
REQ-007 SHALL have ports: rd_MEM  out  5; we_MEM, load_MEM, valid_MEM  out  1; rd_WB  out  5; we_WB, valid_WB  out  1.
REQ-008 SHALL have ports: retired_cnt  out  32  retired instructions; bubble_cnt  out  16  DE bubbles inserted.

Function
REQ-009 PC register SHALL load pc_next when PC_EN_IF=1, else hold.
REQ-010 Each stage register (FD, DE, EM, MW) SHALL follow priority: rst > flush > EN > hold.
REQ-011 Flush SHALL write a bubble: valid=0, rd=0, rs2=0, all flags 0, inst_ID=32'h00000013 (NOP), PC field 0.
REQ-012 FD with reg_FD_EN=1 SHALL capture PC_IF, inst_IF and set valid_ID=1.
REQ-013 DE with reg_DE_EN=1 SHALL capture rd_ID, rs2_ID, we_ID, load_ID, store_ID, valid_ID; EM SHALL capture EXE fields; MW SHALL capture MEM fields.
REQ-014 MW has no flush input; rst is its only bubble source.
REQ-015 Downstream stage enabled while upstream holds SHALL capture the held upstream contents unchanged; no automatic bubble (hazard unit must flush).
REQ-016 Any stage with valid=0 SHALL present rd_*=0 and we_*=0, so bubbles never match a forwarding compare.
REQ-017 Flush and EN asserted together on one stage SHALL produce a bubble.
REQ-018 retired_cnt SHALL increment by 1 on each clk where reg_MW_EN=1 and valid_MEM=1; saturates at 32'hFFFFFFFF.
REQ-019 bubble_cnt SHALL increment by 1 on each clk where reg_DE_flush=1; saturates at 16'hFFFF.
REQ-020 All outputs SHALL be registered; zero combinational path from inputs to outputs.
REQ-021 Latency: instruction at inst_IF with all EN=1 SHALL appear valid_ID +1, valid_EXE +2, valid_MEM +3, valid_WB +4 cycles.

Reset
REQ-022 rst=1 SHALL set PC_IF=0, PC_ID=0, inst_ID=32'h00000013, all valid/flags/rd/rs2=0, retired_cnt=0, bubble_cnt=0, overriding all controls.
REQ-023 rst asserted mid-stream SHALL discard all in-flight instructions on the same edge; counters SHALL not count that edge.

Verification
REQ-024 rst 1 cycle, then all EN=1, pc_next=4,8,12..., inst_IF=ADDI rd=5 -> cycle4: valid_WB=1, rd_WB=5, retired_cnt=1 on next edge.
REQ-025 Load-use: reg_FD_EN=0, PC_EN_IF=0, reg_DE_flush=1 for 1 cycle -> PC_IF, inst_ID held; valid_EXE=0, rd_EXE=0; bubble_cnt=1.
REQ-026 reg_FD_flush=1 with reg_FD_EN=1 -> inst_ID=32'h00000013, valid_ID=0, PC_ID=0.
REQ-027 Stream of 3 instructions, then rst=1 mid-stream -> all valid=0 next edge, retired_cnt=0, bubble_cnt=0.
REQ-028 Force bubble_cnt=16'hFFFF via 65535 flush cycles, one more flush -> bubble_cnt stays 16'hFFFF.
REQ-029 reg_EM_EN=0 for 2 cycles with DE enabled -> rd_MEM, valid_MEM held; retired_cnt unchanged while valid_MEM=0.
